// File: rtl/vram_pkg.sv
// Shared types, constants and decode helpers for the pipelined VRAM mapper.
package vram_pkg;

    localparam int unsigned ADDR_W    = 14;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned PAL_DEPTH = 32;
    localparam int unsigned PAL_IDX_W = 5;

    localparam logic [ADDR_W-1:0] CHR_END  = 14'h2000;
    localparam logic [ADDR_W-1:0] PAL_BASE = 14'h3F00;

    typedef enum logic [2:0] {
        MIR_HORIZ    = 3'd0,
        MIR_VERT     = 3'd1,
        MIR_SINGLE_A = 3'd2,
        MIR_SINGLE_B = 3'd3,
        MIR_FOUR     = 3'd4
    } mirror_t;

    typedef enum logic [1:0] {
        REG_CHR   = 2'd0,
        REG_CIRAM = 2'd1,
        REG_PAL   = 2'd2,
        REG_NONE  = 2'd3
    } region_t;

    // Map a PPU address onto the memory that backs it.
    function automatic region_t decode_region(input logic [ADDR_W-1:0] a);
        if (a < CHR_END) begin
            return REG_CHR;
        end else if (a < PAL_BASE) begin
            return REG_CIRAM;
        end
        return REG_PAL;
    endfunction

    // Reserved codes, and four-screen without the extra CIRAM, fall back to vertical.
    function automatic mirror_t eff_mirror(input logic [2:0] m, input logic four_ok);
        case (m)
            3'd0:    return MIR_HORIZ;
            3'd1:    return MIR_VERT;
            3'd2:    return MIR_SINGLE_A;
            3'd3:    return MIR_SINGLE_B;
            3'd4:    return four_ok ? MIR_FOUR : MIR_VERT;
            default: return MIR_VERT;
        endcase
    endfunction

    // Nametable select bits {A11, A10} placed above addr[9:0] on the CIRAM bus.
    function automatic logic [1:0] nt_select(input mirror_t m, input logic a11, input logic a10);
        case (m)
            MIR_HORIZ:    return {1'b0, a11};
            MIR_VERT:     return {1'b0, a10};
            MIR_SINGLE_A: return 2'b00;
            MIR_SINGLE_B: return 2'b01;
            MIR_FOUR:     return {a11, a10};
            default:      return {1'b0, a10};
        endcase
    endfunction

    // Sprite backdrop entries 0x10/14/18/1C alias the background ones.
    function automatic logic [PAL_IDX_W-1:0] pal_alias(input logic [PAL_IDX_W-1:0] idx);
        return (idx[1:0] == 2'b00) ? {1'b0, idx[3:0]} : idx;
    endfunction

endpackage

// File: rtl/vram_palette_ram.sv
// 32-entry palette RAM: aliased index, synchronous write, registered write-first read.
module vram_palette_ram
    import vram_pkg::*;
#(
    parameter int unsigned PAL_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we_i,
    input  logic [PAL_IDX_W-1:0] idx_i,
    input  logic [PAL_W-1:0]     wdata_i,
    output logic [PAL_W-1:0]     rdata_o
);

    logic [PAL_W-1:0]     mem_q [PAL_DEPTH];
    logic [PAL_W-1:0]     rd_q;
    logic [PAL_IDX_W-1:0] idx;

    assign idx     = pal_alias(idx_i);
    assign rdata_o = rd_q;

    // Storage is not reset; a write squashed by reset must not land.
    always_ff @(posedge clk) begin
        if (we_i && !reset) begin
            mem_q[idx] <= wdata_i;
        end
    end

    // Read port returns the value being written when both hit the same cycle.
    always_ff @(posedge clk) begin
        rd_q <= we_i ? wdata_i : mem_q[idx];
    end

endmodule

// File: rtl/vram_mapper_pipe.sv
// Pipelined PPU VRAM mapper: CHR / CIRAM / palette decode, mirroring, PPUDATA read buffer.
module vram_mapper_pipe
    import vram_pkg::*;
#(
    parameter int unsigned CIRAM_AW   = 11,
    parameter int unsigned CHR_AW     = 13,
    parameter int unsigned CHR_IS_RAM = 0,
    parameter int unsigned PAL_W      = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                we,
    input  logic                cpu_port,
    input  logic [13:0]         addr,
    input  logic [7:0]          wdata,
    input  logic [2:0]          mirror_mode,
    output logic [7:0]          rdata,
    output logic                rvalid,
    output logic [CIRAM_AW-1:0] CIRAM_addr,
    output logic                CIRAM_WE,
    input  logic [7:0]          CIRAM_out,
    output logic [CHR_AW-1:0]   CHR_ROM_addr,
    output logic                CHR_WE,
    input  logic [7:0]          CHR_ROM_out,
    output logic [7:0]          mem_wdata
);

    localparam logic CHR_WR_EN = (CHR_IS_RAM != 0);
    localparam logic FOUR_OK   = (CIRAM_AW == 12);

    // Stage 1 state
    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_we_q, s1_we_d;
    logic                 s1_cpu_q, s1_cpu_d;
    region_t              s1_region_q, s1_region_d;
    logic [CIRAM_AW-1:0]  ciram_addr_q, ciram_addr_d;
    logic                 ciram_we_q, ciram_we_d;
    logic [CHR_AW-1:0]    chr_addr_q, chr_addr_d;
    logic                 chr_we_q, chr_we_d;
    logic [7:0]           mem_wdata_q, mem_wdata_d;
    logic                 pal_we_q, pal_we_d;
    logic [PAL_IDX_W-1:0] pal_idx_q, pal_idx_d;
    logic [PAL_W-1:0]     pal_wdata_q, pal_wdata_d;

    // Stage 2 state
    logic                 s2_rd_q, s2_rd_d;
    logic                 s2_cpu_q, s2_cpu_d;
    region_t              s2_region_q, s2_region_d;
    logic [7:0]           buf_q, buf_d;

    region_t              region;
    mirror_t              mir;
    logic [1:0]           nt;
    logic [11:0]          ciram_full;
    logic [PAL_W-1:0]     pal_rd;
    logic [7:0]           region_data;

    assign CIRAM_addr   = ciram_addr_q;
    assign CIRAM_WE     = ciram_we_q;
    assign CHR_ROM_addr = chr_addr_q;
    assign CHR_WE       = chr_we_q;
    assign mem_wdata    = mem_wdata_q;
    assign rvalid       = s2_rd_q;

    vram_palette_ram #(
        .PAL_W (PAL_W)
    ) u_pal (
        .clk     (clk),
        .reset   (reset),
        .we_i    (pal_we_q),
        .idx_i   (pal_idx_q),
        .wdata_i (pal_wdata_q),
        .rdata_o (pal_rd)
    );

    // Stage 0 -> 1: decode, mirroring and memory-side address/enable generation.
    // Palette accesses also present the nametable underneath (addr & 0x2FFF);
    // the mask only clears A12, which the CIRAM bus never carries.
    always_comb begin
        region      = decode_region(addr);
        mir         = eff_mirror(mirror_mode, FOUR_OK);
        nt          = nt_select(mir, addr[11], addr[10]);
        ciram_full  = {nt, addr[9:0]};

        s1_valid_d  = req;
        s1_we_d     = we;
        s1_cpu_d    = cpu_port;
        s1_region_d = req ? region : REG_NONE;

        ciram_addr_d = ciram_addr_q;
        chr_addr_d   = chr_addr_q;
        mem_wdata_d  = mem_wdata_q;
        pal_idx_d    = pal_idx_q;
        pal_wdata_d  = pal_wdata_q;
        ciram_we_d   = 1'b0;
        chr_we_d     = 1'b0;
        pal_we_d     = 1'b0;

        if (req) begin
            if (we) begin
                mem_wdata_d = wdata;
            end
            case (region)
                REG_CHR: begin
                    chr_addr_d = CHR_AW'(addr);
                    chr_we_d   = we & CHR_WR_EN;
                end
                REG_CIRAM: begin
                    ciram_addr_d = CIRAM_AW'(ciram_full);
                    ciram_we_d   = we;
                end
                REG_PAL: begin
                    ciram_addr_d = CIRAM_AW'(ciram_full);
                    pal_idx_d    = addr[4:0];
                    pal_we_d     = we;
                    pal_wdata_d  = wdata[PAL_W-1:0];
                end
                default: ;
            endcase
        end
    end

    // Stage 1 -> 2: only reads carry forward to the response stage.
    always_comb begin
        s2_rd_d     = s1_valid_q & ~s1_we_q;
        s2_cpu_d    = s1_cpu_q;
        s2_region_d = s1_region_q;
    end

    // Stage 2 response and PPUDATA buffer. The buffer loads at the end of cycle 2,
    // so a CPU read issued on the next cycle already sees it in its own cycle 2.
    always_comb begin
        region_data = 8'h00;
        case (s2_region_q)
            REG_CHR:   region_data = CHR_ROM_out;
            REG_CIRAM: region_data = CIRAM_out;
            REG_PAL:   region_data = 8'(pal_rd);
            default:   region_data = 8'h00;
        endcase

        rdata = 8'h00;
        buf_d = buf_q;
        if (s2_rd_q) begin
            if (s2_cpu_q && (s2_region_q != REG_PAL)) begin
                rdata = buf_q;
            end else begin
                rdata = region_data;
            end
            if (s2_cpu_q) begin
                buf_d = (s2_region_q == REG_PAL) ? CIRAM_out : region_data;
            end
        end
    end

    // Pipeline registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_we_q      <= 1'b0;
            s1_cpu_q     <= 1'b0;
            s1_region_q  <= REG_NONE;
            ciram_addr_q <= '0;
            ciram_we_q   <= 1'b0;
            chr_addr_q   <= '0;
            chr_we_q     <= 1'b0;
            mem_wdata_q  <= 8'h00;
            pal_we_q     <= 1'b0;
            pal_idx_q    <= '0;
            pal_wdata_q  <= '0;
            s2_rd_q      <= 1'b0;
            s2_cpu_q     <= 1'b0;
            s2_region_q  <= REG_NONE;
            buf_q        <= 8'h00;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_we_q      <= s1_we_d;
            s1_cpu_q     <= s1_cpu_d;
            s1_region_q  <= s1_region_d;
            ciram_addr_q <= ciram_addr_d;
            ciram_we_q   <= ciram_we_d;
            chr_addr_q   <= chr_addr_d;
            chr_we_q     <= chr_we_d;
            mem_wdata_q  <= mem_wdata_d;
            pal_we_q     <= pal_we_d;
            pal_idx_q    <= pal_idx_d;
            pal_wdata_q  <= pal_wdata_d;
            s2_rd_q      <= s2_rd_d;
            s2_cpu_q     <= s2_cpu_d;
            s2_region_q  <= s2_region_d;
            buf_q        <= buf_d;
        end
    end

endmodule
